// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle between the decode stage (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 3
);
  logic          flush;
  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_use_rs;
  logic          d_use_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic          d_wr_en;
  logic [AW-1:0] d_wa;
  logic [TW-1:0] d_tnew;
  logic          d_mdu_start;
  logic          d_mdu_div;
  logic          d_mdu_use;
  logic          stall;
  logic          stall_rs;
  logic          stall_rt;
  logic          stall_mdu;
  logic          busy_any;

  modport master (
    output flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wr_en, d_wa, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
    input  stall, stall_rs, stall_rt, stall_mdu, busy_any
  );

  modport slave (
    input  flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wr_en, d_wa, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
    output stall, stall_rs, stall_rt, stall_mdu, busy_any
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse register scoreboard with optional MDU busy tracking.
// Define HAZARD_SCOREBOARD_MDU_EN to enable the mult/div busy counter and stall_mdu.
module hazard_scoreboard #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 3,
  parameter int unsigned MW       = 4,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  sb
);

  logic [TW-1:0] score [NREG-1:1];
  logic [TW-1:0] score_rs;
  logic [TW-1:0] score_rt;
  logic          issue;
  logic          score_busy;
  logic          mdu_busy;

  // Register 0 has no entry: the lookup defaults to 0 and only 1..NREG-1 can match.
  always_comb begin
    score_rs   = '0;
    score_rt   = '0;
    score_busy = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (sb.d_rs == AW'(r)) score_rs = score[r];
      if (sb.d_rt == AW'(r)) score_rt = score[r];
      score_busy = score_busy | (score[r] != '0);
    end
  end

  assign sb.stall_rs = sb.d_valid & sb.d_use_rs & (sb.d_rs != '0) & (score_rs > sb.d_tuse_rs);
  assign sb.stall_rt = sb.d_valid & sb.d_use_rt & (sb.d_rt != '0) & (score_rt > sb.d_tuse_rt);
  assign sb.stall    = sb.stall_rs | sb.stall_rt | sb.stall_mdu;
  assign issue       = sb.d_valid & ~sb.stall & ~sb.flush;
  assign sb.busy_any = score_busy | mdu_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 1; r < NREG; r++) score[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (sb.flush)
          score[r] <= '0;
        else if (issue && sb.d_wr_en && sb.d_wa == AW'(r))
          score[r] <= sb.d_tnew;
        else if (score[r] != '0)
          score[r] <= score[r] - TW'(1);
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_MDU_EN
  logic [MW-1:0] mdu_cnt;

  // flush leaves the MDU running: the operation already left the pipeline.
  always_ff @(posedge clk) begin
    if (reset)
      mdu_cnt <= '0;
    else if (issue && sb.d_mdu_start)
      mdu_cnt <= sb.d_mdu_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - MW'(1);
  end

  assign mdu_busy     = (mdu_cnt != '0);
  assign sb.stall_mdu = sb.d_valid & sb.d_mdu_use & mdu_busy;
`else
  logic unused_mdu;

  assign unused_mdu   = sb.d_mdu_start ^ sb.d_mdu_div ^ sb.d_mdu_use;
  assign mdu_busy     = 1'b0;
  assign sb.stall_mdu = 1'b0;
`endif

endmodule
